if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage of the five-stage pipeline. It owns the program counter, issues requests on the instruction-memory bus, and presents `if_pc`/`if_inst` to the IF/ID pipeline register, which latches them when `stall[1]` is low. The stage tolerates variable-latency memory through a request/acknowledge handshake and a one-entry hold buffer. It redirects the PC for taken branches while honouring the single branch delay slot.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset. One clock; reset is synchronous and active-high (`rst == 1` at a rising edge resets the block).
- `stall` in 6: pipeline stall vector from ctrl. `stall[1]==1` means IF/ID holds. `stall[2]==1` means ID holds. `stall[0]` and `stall[5:3]` are ignored.
- `branch_flag_i` in 1: taken branch or jump decoded in ID this cycle.
- `branch_target_address_i` in 32: branch/jump target. Valid when `branch_flag_i` is 1.
- `inst_req_o` out 1: instruction-memory request.
- `inst_addr_o` out 32: fetch address; equals the PC.
- `inst_ack_i` in 1: memory returns `inst_data_i` this cycle.
- `inst_data_i` in 32: fetched instruction word.
- `if_pc` out 32: PC of the presented instruction, or 0 for a bubble.
- `if_inst` out 32: presented instruction, or 0 (NOP) for a bubble.
- `stallreq_if` out 1: stall request to ctrl while waiting on memory.

## Operation
- Registers: `pc`, `state`, `buf_inst`, `br_pend`, `br_target`.
- `state` is one of three states:
  - S_IDLE: entered on reset. `inst_req_o` is 0. Moves to S_REQ unconditionally on the next edge.
  - S_REQ: `inst_req_o=1` and `inst_addr_o=pc`. Both stay stable until ack.
    - No ack: `if_pc=0`, `if_inst=0`, `stallreq_if=1`.
    - Ack: `if_pc=pc`, `if_inst=inst_data_i`, `stallreq_if=0`.
      - Ack with `stall[1]==0`: the instruction is consumed. `pc` is updated with next_pc and the state stays S_REQ (back-to-back fetch).
      - Ack with `stall[1]==1`: `buf_inst` captures `inst_data_i`, the state moves to S_FULL, and `pc` is unchanged.
  - S_FULL: `inst_req_o=0`, `if_pc=pc`, `if_inst=buf_inst`, `stallreq_if=0`. When `stall[1]==0` the instruction is consumed: `pc` gets next_pc and the state moves to S_REQ.
- Next-PC selection at a consume edge, in priority order:
  1. If `branch_flag_i==1` and `stall[2]==0`, next_pc is `branch_target_address_i`. The consumed instruction is the delay slot.
  2. Otherwise, if `br_pend==1`, next_pc is `br_target`.
  3. Otherwise, next_pc is `pc+4`, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- Branch capture: when `branch_flag_i==1` and `stall[2]==0` at an edge where no consume occurs, set `br_pend=1` and `br_target=branch_target_address_i`. `br_pend` clears at the next consume.
  - With `stall[2]==1`, `branch_flag_i` is ignored; ID re-presents the branch later.
- Reset (any state, including mid-request) sets:
  - `pc=RESET_PC`, `state=S_IDLE`, `br_pend=0`, `br_target=0`, `buf_inst=0`.
  - Outputs `inst_req_o=0`, `if_pc=0`, `if_inst=0`, `stallreq_if=0`.
- Bus contract:
  - The memory drops an outstanding request if `inst_req_o` falls without an ack.
  - An `inst_ack_i` outside S_REQ is ignored.
- The PC is word-aligned by contract. Bits [1:0] of the target are passed through unchecked.

## Timing
- Outputs `if_pc`, `if_inst` and `stallreq_if` are combinational from state, registers and `inst_ack_i`/`inst_data_i` in S_REQ. `inst_req_o` and `inst_addr_o` are combinational from state and `pc` only.
- First request appears in the 2nd cycle after `rst` deasserts.
- Zero-wait memory (ack in the same cycle as req): throughput is one instruction per cycle.
- N-cycle ack latency: `stallreq_if` is high for N cycles per instruction.
- Branch-to-target latency: the delay slot is fetched, then the target in the following request, with no extra bubble when memory is zero-wait.
- Simultaneous ack, `stall[1]==0` and branch: the target is used immediately (rule 1).

## Test plan
- Reset release, zero-wait memory, no stalls: `inst_addr_o` is 0x0, 0x4, 0x8, 0xC on consecutive cycles, and `if_pc` matches each one while `inst_ack_i` is high.
- Ack delayed 3 cycles at PC 0x8: `inst_addr_o` holds 0x8 with `inst_req_o=1`. `stallreq_if` is 1 and `if_inst=0` for 3 cycles. On the ack cycle `if_inst=inst_data_i`, and the next address is 0xC.
- Ack at PC 0x10 with `stall[1]=1` for 2 cycles: the state enters S_FULL and `inst_req_o=0`. `if_pc` holds 0x10 and `if_inst` holds the word. After release, `inst_addr_o` becomes 0x14.
- Branch taken to 0x100 (`stall[2]=0`) while the delay slot at 0x14 is still awaiting ack: `br_pend` is set. The delay slot at 0x14 is delivered, then the next request is 0x100.
- Branch on the same edge as the delay-slot consume at 0x14 (zero-wait): the next `inst_addr_o` is 0x100 and `br_pend` stays 0.
- `rst` asserted mid-request at PC 0x20 with a late ack on the following cycle: `inst_req_o` becomes 0 and the ack is ignored. The first request after release is to 0x0.

Source files
------------

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage.
//
// Owns the program counter and fetches over a req/ack instruction bus. The
// fetched word goes to the IF/ID register, which latches when stall[1] is low.
// A one-entry buffer (buf_inst) holds a word that arrives while IF/ID is
// stalled. Taken branches redirect the PC after the single delay slot.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   stall[5:0]               ctrl stall vector (bit1: IF/ID hold, bit2: ID hold)
//   branch_flag_i            taken branch/jump decoded in ID
//   branch_target_address_i  branch/jump target
//   inst_req_o, inst_addr_o  instruction-memory request and address (= pc)
//   inst_ack_i, inst_data_i  memory acknowledge and returned word
//   if_pc, if_inst           presented PC/instruction (0/0 for a bubble)
//   stallreq_if              stall request while waiting on memory
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_ack_i,
  input  logic [31:0] inst_data_i,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_if
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FULL} state_t;

  state_t      state, next_state;
  logic [31:0] pc, buf_inst, br_target, next_pc;
  logic        br_pend;
  logic        consume;   // IF/ID takes the presented instruction this edge
  logic        capture;   // word arrived but IF/ID is held: park it
  logic        br_take;   // branch from ID is valid this cycle

  // Only bits 1 and 2 of the stall vector matter to this stage.
  logic unused_stall;
  assign unused_stall = ^{stall[5:3], stall[0]};

  assign br_take = branch_flag_i && !stall[2];

  // A branch seen on the consume edge wins; the consumed word is its delay slot.
  always_comb begin
    if (br_take)      next_pc = branch_target_address_i;
    else if (br_pend) next_pc = br_target;
    else              next_pc = pc + 32'd4;
  end

  always_comb begin
    next_state  = state;
    inst_req_o  = 1'b0;
    inst_addr_o = pc;
    if_pc       = 32'h0;
    if_inst     = 32'h0;
    stallreq_if = 1'b0;
    consume     = 1'b0;
    capture     = 1'b0;
    case (state)
      S_IDLE: next_state = S_REQ;
      S_REQ: begin
        inst_req_o = 1'b1;
        if (inst_ack_i) begin
          if_pc   = pc;
          if_inst = inst_data_i;
          if (!stall[1]) begin
            consume = 1'b1;
          end else begin
            capture    = 1'b1;
            next_state = S_FULL;
          end
        end else begin
          stallreq_if = 1'b1;
        end
      end
      S_FULL: begin
        // Request dropped here, so any stray ack is ignored.
        if_pc   = pc;
        if_inst = buf_inst;
        if (!stall[1]) begin
          consume    = 1'b1;
          next_state = S_REQ;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      buf_inst  <= 32'h0;
      br_pend   <= 1'b0;
      br_target <= 32'h0;
    end else begin
      state <= next_state;
      if (capture) buf_inst <= inst_data_i;
      if (consume) begin
        pc      <= next_pc;
        br_pend <= 1'b0;
      end else if (br_take) begin
        br_pend   <= 1'b1;
        br_target <= branch_target_address_i;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: reset, zero-wait and delayed fetch, IF/ID hold
// buffering, branch delay-slot handling, PC wrap and mid-request reset.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_ack_i;
  logic [31:0] inst_data_i;
  logic [31:0] if_pc, if_inst;
  logic        stallreq_if;

  int checks = 0;
  int failures = 0;

  if_fetch #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_flag_i(branch_flag_i),
    .branch_target_address_i(branch_target_address_i),
    .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o),
    .inst_ack_i(inst_ack_i), .inst_data_i(inst_data_i),
    .if_pc(if_pc), .if_inst(if_inst), .stallreq_if(stallreq_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs are driven 1ns after a rising edge; outputs are sampled mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ack, input logic [31:0] data, input logic [5:0] stl,
                       input logic br, input logic [31:0] tgt);
    inst_ack_i = ack; inst_data_i = data; stall = stl;
    branch_flag_i = br; branch_target_address_i = tgt;
    #4;
  endtask

  // Zero-wait consume at expected address.
  task automatic fetch0(input string tag, input logic [31:0] addr, input logic [31:0] data);
    drive(1'b1, data, 6'h0, 1'b0, 32'h0);
    chk({tag, "_addr"}, inst_addr_o, addr);
    chk({tag, "_pc"},   if_pc, addr);
    chk({tag, "_inst"}, if_inst, data);
    step();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 6'h0, 1'b0, 32'h0);
    step(); step();
    rst = 1'b0;
    drive(1'b0, 32'h0, 6'h0, 1'b0, 32'h0);
    chk("rst_req",   {31'h0, inst_req_o}, 32'h0);
    chk("rst_pc",    if_pc, 32'h0);
    chk("rst_inst",  if_inst, 32'h0);
    chk("rst_stall", {31'h0, stallreq_if}, 32'h0);
    step();

    // Zero-wait fetches at 0x0, 0x4.
    fetch0("zw0", 32'h0, 32'hA000_0000);
    fetch0("zw4", 32'h4, 32'hA000_0004);

    // Ack delayed 3 cycles at 0x8.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'hDEAD_BEEF, 6'h0, 1'b0, 32'h0);
      chk("wait_req",   {31'h0, inst_req_o}, 32'h1);
      chk("wait_addr",  inst_addr_o, 32'h8);
      chk("wait_stall", {31'h0, stallreq_if}, 32'h1);
      chk("wait_inst",  if_inst, 32'h0);
      chk("wait_pc",    if_pc, 32'h0);
      step();
    end
    drive(1'b1, 32'hA000_0008, 6'h0, 1'b0, 32'h0);
    chk("ack8_inst",  if_inst, 32'hA000_0008);
    chk("ack8_stall", {31'h0, stallreq_if}, 32'h0);
    step();
    fetch0("zwC", 32'hC, 32'hA000_000C);

    // Ack at 0x10 while IF/ID is held for 2 cycles.
    drive(1'b1, 32'hB000_0010, 6'h02, 1'b0, 32'h0);
    chk("hold_pc0",   if_pc, 32'h10);
    chk("hold_inst0", if_inst, 32'hB000_0010);
    step();
    drive(1'b1, 32'h1234_5678, 6'h02, 1'b0, 32'h0);  // stray ack ignored
    chk("full_req",   {31'h0, inst_req_o}, 32'h0);
    chk("full_pc",    if_pc, 32'h10);
    chk("full_inst",  if_inst, 32'hB000_0010);
    chk("full_stall", {31'h0, stallreq_if}, 32'h0);
    step();
    drive(1'b0, 32'h0, 6'h00, 1'b0, 32'h0);
    chk("rel_inst", if_inst, 32'hB000_0010);
    step();

    // Branch while delay slot 0x14 awaits ack; stall[2]-masked branch ignored first.
    drive(1'b0, 32'h0, 6'h04, 1'b1, 32'h0000_0200);
    chk("ds_addr",  inst_addr_o, 32'h14);
    chk("ds_stall", {31'h0, stallreq_if}, 32'h1);
    step();
    drive(1'b0, 32'h0, 6'h00, 1'b1, 32'h0000_0100);
    step();
    drive(1'b1, 32'hC000_0014, 6'h00, 1'b0, 32'h0);
    chk("ds_pc",   if_pc, 32'h14);
    chk("ds_inst", if_inst, 32'hC000_0014);
    step();
    fetch0("tgt100", 32'h100, 32'hC000_0100);
    // Branch on the consume edge at 0x104: target used immediately.
    drive(1'b1, 32'hC000_0104, 6'h00, 1'b1, 32'h0000_0200);
    chk("same_pc", if_pc, 32'h104);
    step();
    fetch0("tgt200", 32'h200, 32'hC000_0200);
    drive(1'b0, 32'h0, 6'h00, 1'b0, 32'h0);
    chk("nopend_addr", inst_addr_o, 32'h204);

    // PC wrap at 0xFFFF_FFFC.
    drive(1'b1, 32'hC000_0204, 6'h00, 1'b1, 32'hFFFF_FFFC);
    step();
    fetch0("wrapFC", 32'hFFFF_FFFC, 32'hE000_0000);
    drive(1'b1, 32'hE000_0001, 6'h00, 1'b1, 32'h0000_0020);
    chk("wrap0_addr", inst_addr_o, 32'h0);
    step();

    // Reset mid-request at 0x20, late ack on the next cycle.
    drive(1'b0, 32'h0, 6'h00, 1'b0, 32'h0);
    chk("pre_rst_addr", inst_addr_o, 32'h20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b1, 32'hF00D_F00D, 6'h00, 1'b0, 32'h0);
    chk("mrst_req",   {31'h0, inst_req_o}, 32'h0);
    chk("mrst_inst",  if_inst, 32'h0);
    chk("mrst_pc",    if_pc, 32'h0);
    chk("mrst_stall", {31'h0, stallreq_if}, 32'h0);
    step();
    drive(1'b0, 32'h0, 6'h00, 1'b0, 32'h0);
    chk("post_rst_req",  {31'h0, inst_req_o}, 32'h1);
    chk("post_rst_addr", inst_addr_o, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
